// File: rtl/flex_updown_counter.sv
`default_nettype none
// ============================================================================
// Module : flex_updown_counter
// Brief  : Parametrised up/down counter with load, clear, wrap/saturate mode,
//          rollover/rollunder flags and a wrap-event pulse.
// Rev    : 1.0  initial release
// ============================================================================
module flex_updown_counter #(
  parameter int NUM_CNT_BITS = 4,
  parameter int WRAP_LOW     = 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic                    saturate,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    rollunder_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] c_wrap_low = NUM_CNT_BITS'(WRAP_LOW);
  localparam logic [NUM_CNT_BITS-1:0] c_zero     = '0;
  localparam logic [NUM_CNT_BITS-1:0] c_one      = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    rollover_q, rollover_d;
  logic                    rollunder_q, rollunder_d;
  logic                    wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = c_zero;
    end else if (load) begin
      count_d = (load_val > rollover_val) ? rollover_val : load_val;
    end else if (count_enable) begin
      if (rollover_val == c_zero) begin
        count_d = c_zero;
      end else if (count_up) begin
        // Increment only below the bound, so the +1 can never overflow.
        if (count_q >= rollover_val) begin
          if (saturate) begin
            count_d = rollover_val;
          end else begin
            count_d = c_wrap_low;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + c_one;
        end
      end else begin
        // A bound lowered below the current count pulls the count down to it.
        if (count_q > rollover_val) begin
          count_d = rollover_val;
        end else if (count_q <= c_wrap_low) begin
          if (!saturate) begin
            count_d = rollover_val;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - c_one;
        end
      end
    end
    rollover_d  = (count_d == rollover_val);
    rollunder_d = (count_d == c_wrap_low);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q     <= c_zero;
      rollover_q  <= 1'b0;
      rollunder_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      rollover_q  <= rollover_d;
      rollunder_q <= rollunder_d;
      wrap_q      <= wrap_d;
    end
  end

  assign count_out      = count_q;
  assign rollover_flag  = rollover_q;
  assign rollunder_flag = rollunder_q;
  assign wrap_pulse     = wrap_q;

endmodule
`default_nettype wire
